vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_RES, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_RES, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter COUNTER_BITS, default 10, width of h_count and v_count.
REQ-010 SHALL have port clk_50MHz, input, 1, the single system clock.
REQ-011 SHALL have port clear, input, 1, reset: synchronous, active-high.
REQ-012 SHALL have port clk_25MHz, output, 1, pixel clock, a divide-by-2 square wave.
REQ-013 SHALL have port pix_en, output, 1, one-cycle pixel-advance strobe at 25 MHz rate.
REQ-014 SHALL have port h_count, output, COUNTER_BITS, current pixel column.
REQ-015 SHALL have port v_count, output, COUNTER_BITS, current line.
REQ-016 SHALL have ports h_sync and v_sync, output, 1 each, active-low sync.
REQ-017 SHALL have port bright, output, 1, high while in the visible region.
REQ-018 SHALL have ports line_end and frame_end, output, 1 each, single-cycle pulses.

Function
REQ-019 SHALL use H_TOTAL = H_RES+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_RES+V_FP+V_SYNC+V_BP (525); COUNTER_BITS SHALL hold H_TOTAL-1 and V_TOTAL-1.
REQ-020 clk_25MHz SHALL toggle on every clk_50MHz edge; pix_en SHALL be high exactly in the cycles where clk_25MHz is 1.
REQ-021 h_count SHALL increment only on cycles with pix_en=1 and wrap from H_TOTAL-1 (799) to 0.
REQ-022 v_count SHALL increment only when pix_en=1 and h_count=H_TOTAL-1, and wrap from V_TOTAL-1 (524) to 0 in that same cycle.
REQ-023 h_sync SHALL be 0 iff H_RES+H_FP <= h_count < H_RES+H_FP+H_SYNC (656..751); otherwise 1.
REQ-024 v_sync SHALL be 0 iff V_RES+V_FP <= v_count < V_RES+V_FP+V_SYNC (490..491); otherwise 1.
REQ-025 bright SHALL be 1 iff h_count < H_RES and v_count < V_RES.
REQ-026 h_sync, v_sync and bright SHALL be zero-latency decodes of the registered counters, valid in the same cycle as the count value.
REQ-027 line_end SHALL be 1 for exactly one clk_50MHz cycle: pix_en=1 and h_count=799.
REQ-028 frame_end SHALL be 1 for exactly one cycle: line_end=1 and v_count=524; it never asserts without line_end.
REQ-029 Every frame SHALL be exactly 2*H_TOTAL*V_TOTAL = 840000 clk_50MHz cycles long.
REQ-030 Counters SHALL never hold values at or above H_TOTAL / V_TOTAL.

Reset
REQ-031 clear=1 at a clock edge SHALL set clk_25MHz=0, pix_en=0, h_count=0, v_count=0, line_end=0 and frame_end=0 at that edge, regardless of the current position in the frame.
REQ-032 During and right after reset SHALL hold h_sync=1 and v_sync=1; bright=1 (position 0,0).
REQ-033 On the first edge after clear falls, clk_25MHz SHALL become 1, and counting SHALL start from (0,0); clear held high SHALL freeze all state.

Verification
REQ-034 Reset then release: pix_en pulses every 2nd cycle; h_count reaches 1 on the 2nd pix_en; first h_sync falls at h_count=656, i.e. 1312 clocks after the first pix_en.
REQ-035 Run one full frame: exactly 525 line_end pulses, one frame_end, 840000 clocks between consecutive frame_end pulses.
REQ-036 Count bright=1 with pix_en=1 over one frame -> 307200; h_sync low for 96 pix_en per line; v_sync low for 1600 pix_en per frame.
REQ-037 Wrap check: at h_count=799, v_count=524 with pix_en=1 -> next values (0,0) and frame_end=1 in that cycle.
REQ-038 Assert clear mid-frame (v_count=300, h_count=700, h_sync=0) -> next cycle (0,0), h_sync=1, clk_25MHz=0, no line_end/frame_end pulse.

Source files
------------

// File: rtl/vga_timing.sv
// VGA raster timing generator: divides the system clock by two into a pixel
// strobe, walks the raster position and decodes sync, blanking and end-of pulses.
module vga_timing #(
  parameter int H_RES        = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_RES        = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int COUNTER_BITS = 10
) (
  input  logic                    clk_50MHz,
  input  logic                    clear,
  output logic                    clk_25MHz,
  output logic                    pix_en,
  output logic [COUNTER_BITS-1:0] h_count,
  output logic [COUNTER_BITS-1:0] v_count,
  output logic                    h_sync,
  output logic                    v_sync,
  output logic                    bright,
  output logic                    line_end,
  output logic                    frame_end
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [COUNTER_BITS-1:0] H_MAX     = COUNTER_BITS'(H_TOTAL - 1);
  localparam logic [COUNTER_BITS-1:0] V_MAX     = COUNTER_BITS'(V_TOTAL - 1);
  localparam logic [COUNTER_BITS-1:0] H_VIS     = COUNTER_BITS'(H_RES);
  localparam logic [COUNTER_BITS-1:0] V_VIS     = COUNTER_BITS'(V_RES);
  localparam logic [COUNTER_BITS-1:0] H_SYNC_LO = COUNTER_BITS'(H_RES + H_FP);
  localparam logic [COUNTER_BITS-1:0] H_SYNC_HI = COUNTER_BITS'(H_RES + H_FP + H_SYNC);
  localparam logic [COUNTER_BITS-1:0] V_SYNC_LO = COUNTER_BITS'(V_RES + V_FP);
  localparam logic [COUNTER_BITS-1:0] V_SYNC_HI = COUNTER_BITS'(V_RES + V_FP + V_SYNC);

  logic h_last;
  logic v_last;

  // The pixel strobe is the divided clock itself, so the advance happens at
  // the system edge that ends the high half of each pixel period.
  assign pix_en = clk_25MHz;
  assign h_last = (h_count == H_MAX);
  assign v_last = (v_count == V_MAX);

  always_ff @(posedge clk_50MHz) begin
    if (clear) begin
      clk_25MHz <= 1'b0;
      h_count   <= '0;
      v_count   <= '0;
    end else begin
      clk_25MHz <= ~clk_25MHz;
      if (pix_en) begin
        if (h_last) begin
          h_count <= '0;
          v_count <= v_last ? '0 : v_count + 1'b1;
        end else begin
          h_count <= h_count + 1'b1;
        end
      end
    end
  end

  assign h_sync    = ~((h_count >= H_SYNC_LO) && (h_count < H_SYNC_HI));
  assign v_sync    = ~((v_count >= V_SYNC_LO) && (v_count < V_SYNC_HI));
  assign bright    = (h_count < H_VIS) && (v_count < V_VIS);
  assign line_end  = pix_en && h_last;
  assign frame_end = line_end && v_last;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing with a reduced raster (32 x 15) so whole frames fit in a
// short run; a position model derived from elapsed cycles checks every cycle.
module tb_vga_timing;

  localparam int HR = 16, HF = 4, HS = 6, HB = 6;
  localparam int VR = 8,  VF = 2, VS = 2, VB = 3;
  localparam int CB = 10;
  localparam int HT = HR + HF + HS + HB;  // 32
  localparam int VT = VR + VF + VS + VB;  // 15

  logic          clk = 1'b0;
  logic          clear = 1'b1;
  logic          clk_25MHz, pix_en, h_sync, v_sync, bright, line_end, frame_end;
  logic [CB-1:0] h_count, v_count;

  vga_timing #(
    .H_RES(HR), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_RES(VR), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .COUNTER_BITS(CB)
  ) dut (
    .clk_50MHz(clk), .clear(clear), .clk_25MHz(clk_25MHz), .pix_en(pix_en),
    .h_count(h_count), .v_count(v_count), .h_sync(h_sync), .v_sync(v_sync),
    .bright(bright), .line_end(line_end), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: n = system edges since clear was last sampled low (-1 while in reset).
  int n = -1;
  bit model_ok = 1'b0;
  always @(posedge clk) begin
    n <= clear ? -1 : n + 1;
    if (clear) model_ok <= 1'b1;
  end

  always @(negedge clk) begin
    int  k, h, v;
    bit  ck, le;
    if (model_ok) begin
      if (n < 0) begin
        ck = 1'b0; h = 0; v = 0;
      end else begin
        ck = (n % 2 == 0);
        k  = (n + 1) / 2;           // pixels advanced so far
        h  = k % HT;
        v  = (k / HT) % VT;
      end
      le = ck && (h == HT - 1);
      check("m_clk25",   32'(clk_25MHz), 32'(ck));
      check("m_pix_en",  32'(pix_en),    32'(ck));
      check("m_h_count", 32'(h_count),   32'(h));
      check("m_v_count", 32'(v_count),   32'(v));
      check("m_h_sync",  32'(h_sync),    32'(!(h >= HR + HF && h < HR + HF + HS)));
      check("m_v_sync",  32'(v_sync),    32'(!(v >= VR + VF && v < VR + VF + VS)));
      check("m_bright",  32'(bright),    32'(h < HR && v < VR));
      check("m_line_end",  32'(line_end),  32'(le));
      check("m_frame_end", 32'(frame_end), 32'(le && v == VT - 1));
    end
  end

  int cyc, lines, frames, br, hl, vl;
  bit found;

  initial begin
    clear = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_h", 32'(h_count), 0);
    check("rst_v", 32'(v_count), 0);
    check("rst_clk25", 32'(clk_25MHz), 0);
    check("rst_hsync", 32'(h_sync), 1);
    check("rst_vsync", 32'(v_sync), 1);
    check("rst_bright", 32'(bright), 1);
    check("rst_line_end", 32'(line_end), 0);

    clear = 1'b0;
    @(negedge clk);
    check("first_clk25", 32'(clk_25MHz), 1);
    check("first_pix_en", 32'(pix_en), 1);
    // first pix_en is cycle 0; h_sync region starts at h=20 -> pix_en there at cycle 40
    cyc = 0; found = 0;
    while (!found && cyc < 200) begin
      @(negedge clk); cyc++;
      if (cyc == 1) check("pe_gap", 32'(pix_en), 0);
      if (cyc == 2) begin
        check("h_at_2nd_pe", 32'(h_count), 1);
        check("pe_2nd", 32'(pix_en), 1);
      end
      if (pix_en && !h_sync) found = 1;
    end
    check("hsync_fall_cycle", 32'(cyc), 40);
    check("hsync_fall_h", 32'(h_count), 20);

    cyc = 0;
    while (!frame_end && cyc < 2000) begin @(negedge clk); cyc++; end
    check("wait_frame_end", 32'(frame_end), 1);

    cyc = 0; lines = 0; frames = 0; br = 0; hl = 0; vl = 0;
    do begin
      @(negedge clk); cyc++;
      lines  += int'(line_end);
      frames += int'(frame_end);
      br += int'(bright && pix_en);
      hl += int'(!h_sync && pix_en);
      vl += int'(!v_sync && pix_en);
    end while (!frame_end && cyc < 2000);
    check("frame_cycles", 32'(cyc), 960);
    check("frame_lines", 32'(lines), 15);
    check("frame_ends", 32'(frames), 1);
    check("bright_pixels", 32'(br), 128);
    check("hsync_low_pe", 32'(hl), 90);
    check("vsync_low_pe", 32'(vl), 64);
    check("wrap_h_before", 32'(h_count), HT - 1);
    check("wrap_v_before", 32'(v_count), VT - 1);
    @(negedge clk);
    check("wrap_h_after", 32'(h_count), 0);
    check("wrap_v_after", 32'(v_count), 0);

    cyc = 0;
    while (!(v_count == 10 && h_count == 22) && cyc < 2000) begin @(negedge clk); cyc++; end
    check("mid_reached", 32'(v_count == 10 && h_count == 22), 1);
    check("mid_hsync_low", 32'(h_sync), 0);
    clear = 1'b1;
    @(negedge clk);
    check("clr_h", 32'(h_count), 0);
    check("clr_v", 32'(v_count), 0);
    check("clr_hsync", 32'(h_sync), 1);
    check("clr_clk25", 32'(clk_25MHz), 0);
    check("clr_line_end", 32'(line_end), 0);
    check("clr_frame_end", 32'(frame_end), 0);
    repeat (3) @(negedge clk);
    check("hold_h", 32'(h_count), 0);
    check("hold_clk25", 32'(clk_25MHz), 0);
    clear = 1'b0;
    repeat (100) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
